// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   state_t : arbiter FSM states (IDLE, ISSUE, RESP)
//   PORT_C  : grant index of the core load/store unit
//   PORT_L  : grant index of the program/data loader
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_L = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between the core and the loader.
//   req_c, req_l : eligible requests
//   last_grant   : port granted most recently (PORT_C / PORT_L)
//   lock         : loader holds the grant; only req_l is considered
//   valid        : a winner exists
//   grant        : winning port index
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic req_c,
  input  logic req_l,
  input  logic last_grant,
  input  logic lock,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = 1'b0;
    grant = PORT_C;
    if (lock) begin
      valid = req_l;
      grant = PORT_L;
    end else if (req_c && req_l) begin
      valid = 1'b1;
      grant = ~last_grant;
    end else if (req_c) begin
      valid = 1'b1;
      grant = PORT_C;
    end else if (req_l) begin
      valid = 1'b1;
      grant = PORT_L;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-ported synchronous-read data memory between the core
// (port C) and the loader (port L). Each request becomes one memory access
// (ISSUE) followed by a one-cycle ack with read data (RESP).
//   clk, rst                         : clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata/c_ack  : core request port
//   c_stall                          : c_req & ~c_ack
//   l_req/l_we/l_addr/l_wdata/l_ack  : loader request port
//   l_lock                           : loader keeps the grant for bursts
//   rdata                            : read data, valid while an ack is high
//   mem_en/mem_w_en/mem_addr/mem_wdata/mem_rdata : memory macro port
//   c_wait_cnt                       : saturating count of c_stall cycles
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic [DATA_W/8-1:0]   c_we,
  input  logic [ADDR_W-1:0]     c_addr,
  input  logic [DATA_W-1:0]     c_wdata,
  output logic                  c_ack,
  output logic                  c_stall,
  input  logic                  l_req,
  input  logic [DATA_W/8-1:0]   l_we,
  input  logic [ADDR_W-1:0]     l_addr,
  input  logic [DATA_W-1:0]     l_wdata,
  output logic                  l_ack,
  input  logic                  l_lock,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_w_en,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CNT_W-1:0]      c_wait_cnt
);

  state_t               state;
  state_t               state_nxt;
  logic                 gnt;
  logic                 last_grant;
  logic                 rd_q;
  logic                 elig_c;
  logic                 elig_l;
  logic                 lock_eff;
  logic                 pick_valid;
  logic                 pick;
  logic                 take;
  logic [DATA_W/8-1:0]  sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  assign c_stall = c_req & ~c_ack;

  // In RESP the acked port still shows req high, so it is masked out,
  // except a locked loader which keeps the grant and shuts the core out.
  always_comb begin
    elig_c   = c_req;
    elig_l   = l_req;
    lock_eff = 1'b0;
    if (state == RESP) begin
      lock_eff = l_lock && (gnt == PORT_L);
      if (gnt == PORT_C) begin
        elig_c = 1'b0;
      end else if (!l_lock) begin
        elig_l = 1'b0;
      end
    end
  end

  rr_arbiter2 u_rr (
    .req_c      (elig_c),
    .req_l      (elig_l),
    .last_grant (last_grant),
    .lock       (lock_eff),
    .valid      (pick_valid),
    .grant      (pick)
  );

  always_comb begin
    sel_we    = (pick == PORT_L) ? l_we    : c_we;
    sel_addr  = (pick == PORT_L) ? l_addr  : c_addr;
    sel_wdata = (pick == PORT_L) ? l_wdata : c_wdata;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = pick_valid ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign take = (state_nxt == ISSUE);

  // mem_addr/mem_wdata double as the request latches; mem_w_en is loaded
  // only for the ISSUE cycle so it reads zero everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= PORT_C;
      last_grant <= PORT_L;
      c_ack      <= 1'b0;
      l_ack      <= 1'b0;
      rd_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_w_en   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      c_wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      mem_en   <= take;
      mem_w_en <= take ? sel_we : '0;
      if (take) begin
        gnt        <= pick;
        last_grant <= pick;
        mem_addr   <= sel_addr;
        mem_wdata  <= sel_wdata;
      end
      c_ack <= (state == ISSUE) && (gnt == PORT_C);
      l_ack <= (state == ISSUE) && (gnt == PORT_L);
      rd_q  <= (state == ISSUE) && (mem_w_en == '0);
      if (c_stall && (c_wait_cnt != '1)) begin
        c_wait_cnt <= c_wait_cnt + CNT_W'(1);
      end
    end
  end

  // The memory macro's output register is the pipeline stage for read
  // data; it is forwarded only during a read ack, zero otherwise.
  assign rdata = rd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        c_req, c_ack, c_stall;
  logic [3:0]  c_we;
  logic [31:0] c_addr, c_wdata;
  logic        l_req, l_ack, l_lock;
  logic [3:0]  l_we;
  logic [31:0] l_addr, l_wdata;
  logic [31:0] rdata;
  logic        mem_en;
  logic [3:0]  mem_w_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] c_wait_cnt;

  // second instance with a 4-bit wait counter
  logic        rst2, s_c_req, s_c_ack, s_c_stall, s_l_ack, s_mem_en, s_zb;
  logic [3:0]  s_zwe, s_mem_w_en, s_cnt;
  logic [31:0] s_zd, s_rdata, s_mem_addr, s_mem_wdata;
  assign s_zb  = 1'b0;
  assign s_zwe = 4'h0;
  assign s_zd  = 32'h0;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_stall(c_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_lock(l_lock),
    .rdata(rdata), .mem_en(mem_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .c_wait_cnt(c_wait_cnt)
  );

  dmem_port_arbiter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2),
    .c_req(s_c_req), .c_we(s_zwe), .c_addr(s_zd), .c_wdata(s_zd),
    .c_ack(s_c_ack), .c_stall(s_c_stall),
    .l_req(s_zb), .l_we(s_zwe), .l_addr(s_zd), .l_wdata(s_zd),
    .l_ack(s_l_ack), .l_lock(s_zb),
    .rdata(s_rdata), .mem_en(s_mem_en), .mem_w_en(s_mem_w_en),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_zd),
    .c_wait_cnt(s_cnt)
  );

  // synchronous-read memory macro, 8 words
  logic [31:0] mem [8] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_w_en[b]) mem[mem_addr[4:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[4:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    c_req = 0; l_req = 0; l_lock = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({c_ack, l_ack, mem_en, mem_w_en} !== 7'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000000", {c_ack, l_ack, mem_en, mem_w_en});
    end
    n_chk++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    n_chk++;
    if (rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    n_chk++;
    if (c_wait_cnt !== 16'h0 || c_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_cnt: got cnt %0d stall %b want 0 0", c_wait_cnt, c_stall);
    end
  endtask

  task automatic test_core_read();
    int n;
    // seed 0x10 through the core, then start clean
    c_we = 4'hF; c_addr = 32'h10; c_wdata = 32'hDEADBEEF; c_req = 1;
    n = 0;
    do begin tick(); n++; end while (!c_ack && n < 8);
    n_chk++;
    if (c_ack !== 1'b1) begin
      n_fail++; $display("FAIL seed_write_ack: got %b want 1 within 8 cycles", c_ack);
    end
    c_req = 0;
    tick();
    do_reset();
    c_we = 4'h0; c_addr = 32'h10; c_req = 1;
    tick();
    n_chk++;
    if (mem_en !== 1'b1 || mem_w_en !== 4'h0 || mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL read_issue: got en %b we %h addr %h want 1 0 10", mem_en, mem_w_en, mem_addr);
    end
    tick();
    n_chk++;
    if (c_ack !== 1'b1 || l_ack !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL read_ack: got ack %b/%b rdata %h want 1/0 deadbeef", c_ack, l_ack, rdata);
    end
    n_chk++;
    if (c_wait_cnt !== 16'd2) begin
      n_fail++; $display("FAIL read_wait_cnt: got %0d want 2", c_wait_cnt);
    end
    c_req = 0;
    tick();
    n_chk++;
    if (c_ack !== 1'b0 || mem_en !== 1'b0 || c_wait_cnt !== 16'd2) begin
      n_fail++; $display("FAIL read_after: got ack %b en %b cnt %0d want 0 0 2", c_ack, mem_en, c_wait_cnt);
    end
  endtask

  task automatic test_sb();
    do_reset();
    c_we = 4'b0001; c_addr = 32'h3; c_wdata = 32'h000000A5; c_req = 1;
    tick();
    n_chk++;
    if (mem_en !== 1'b1 || mem_w_en !== 4'b0001 || mem_addr !== 32'h3 || mem_wdata !== 32'hA5) begin
      n_fail++; $display("FAIL sb_issue: got en %b we %b addr %h wd %h want 1 0001 3 a5", mem_en, mem_w_en, mem_addr, mem_wdata);
    end
    tick();
    n_chk++;
    if (mem_w_en !== 4'b0000 || c_ack !== 1'b1) begin
      n_fail++; $display("FAIL sb_resp: got we %b ack %b want 0000 1", mem_w_en, c_ack);
    end
    c_req = 0; c_we = 4'h0;
    tick();
    n_chk++;
    if (mem_w_en !== 4'b0000 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL sb_after: got we %b en %b want 0000 0", mem_w_en, mem_en);
    end
  endtask

  task automatic test_tie();
    do_reset();
    c_we = 4'h0; c_addr = 32'h20; c_req = 1;
    l_we = 4'hF; l_addr = 32'h24; l_wdata = 32'h11223344; l_req = 1;
    tick();
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h20) begin
      n_fail++; $display("FAIL tie_first_c: got en %b addr %h want 1 20", mem_en, mem_addr);
    end
    tick();
    n_chk++;
    if (c_ack !== 1'b1 || l_ack !== 1'b0) begin
      n_fail++; $display("FAIL tie_c_ack: got c %b l %b want 1 0", c_ack, l_ack);
    end
    c_addr = 32'h28;   // core immediately asks again
    tick();
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h24 || mem_w_en !== 4'hF || mem_wdata !== 32'h11223344) begin
      n_fail++; $display("FAIL tie_then_l: got en %b addr %h we %h wd %h want 1 24 f 11223344", mem_en, mem_addr, mem_w_en, mem_wdata);
    end
    tick();
    n_chk++;
    if (l_ack !== 1'b1 || c_ack !== 1'b0) begin
      n_fail++; $display("FAIL tie_l_ack: got l %b c %b want 1 0", l_ack, c_ack);
    end
    l_req = 0;
    tick();
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h28) begin
      n_fail++; $display("FAIL tie_c_again: got en %b addr %h want 1 28", mem_en, mem_addr);
    end
    tick();
    n_chk++;
    if (c_ack !== 1'b1) begin
      n_fail++; $display("FAIL tie_c2_ack: got %b want 1", c_ack);
    end
    c_req = 0;
    tick();
    n_chk++;
    if (mem_en !== 1'b0 || c_ack !== 1'b0) begin
      n_fail++; $display("FAIL tie_idle: got en %b ack %b want 0 0", mem_en, c_ack);
    end
  endtask

  task automatic test_burst();
    logic [31:0] beat [4];
    for (int k = 0; k < 4; k++) beat[k] = $urandom;
    do_reset();
    // one core read so that the loader wins the following tie
    c_we = 4'h0; c_addr = 32'h30; c_req = 1;
    tick();
    tick();
    c_req = 0;
    tick();
    c_req = 1;
    l_we = 4'hF; l_lock = 1; l_req = 1; l_addr = 32'h0; l_wdata = beat[0];
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++;
      if (mem_en !== 1'b1 || mem_addr !== 32'(4*k) || mem_wdata !== beat[k] || mem_w_en !== 4'hF) begin
        n_fail++; $display("FAIL burst_issue%0d: got en %b addr %h wd %h we %h want 1 %h %h f", k, mem_en, mem_addr, mem_wdata, mem_w_en, 32'(4*k), beat[k]);
      end
      tick();
      n_chk++;
      if (l_ack !== 1'b1 || c_ack !== 1'b0) begin
        n_fail++; $display("FAIL burst_ack%0d: got l %b c %b want 1 0", k, l_ack, c_ack);
      end
      if (k < 3) begin
        l_addr = 32'(4*(k+1)); l_wdata = beat[k+1];
      end else begin
        l_req = 0; l_lock = 0;
      end
    end
    tick();
    n_chk++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h30 || mem_w_en !== 4'h0) begin
      n_fail++; $display("FAIL burst_core_issue: got en %b addr %h we %h want 1 30 0", mem_en, mem_addr, mem_w_en);
    end
    tick();
    n_chk++;
    if (c_ack !== 1'b1) begin
      n_fail++; $display("FAIL burst_core_ack: got %b want 1", c_ack);
    end
    n_chk++;
    if (c_wait_cnt !== 16'd12) begin
      n_fail++; $display("FAIL burst_wait_cnt: got %0d want 12 (2 + 10)", c_wait_cnt);
    end
    c_req = 0;
    tick();
  endtask

  task automatic test_rst_issue();
    do_reset();
    c_we = 4'h0; c_addr = 32'h14; c_req = 1;
    tick();
    n_chk++;
    if (mem_en !== 1'b1) begin
      n_fail++; $display("FAIL rst_issue_access: got en %b want 1", mem_en);
    end
    rst = 1; c_req = 0;
    tick();
    rst = 0;
    n_chk++;
    if ({c_ack, l_ack, mem_en, mem_w_en} !== 7'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        rdata !== 32'h0 || c_wait_cnt !== 16'h0) begin
      n_fail++; $display("FAIL rst_issue_clear: got ack %b/%b en %b addr %h rdata %h cnt %0d want all 0", c_ack, l_ack, mem_en, mem_addr, rdata, c_wait_cnt);
    end
    tick();
    n_chk++;
    if (c_ack !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_issue_no_ack: got ack %b en %b want 0 0", c_ack, mem_en);
    end
    // reset during RESP: ack still visible that cycle
    c_req = 1;
    tick();
    tick();
    n_chk++;
    if (c_ack !== 1'b1) begin
      n_fail++; $display("FAIL rst_resp_ack: got %b want 1", c_ack);
    end
    rst = 1; c_req = 0;
    tick();
    rst = 0;
    n_chk++;
    if (c_ack !== 1'b0 || mem_en !== 1'b0 || c_wait_cnt !== 16'h0) begin
      n_fail++; $display("FAIL rst_resp_clear: got ack %b en %b cnt %0d want 0 0 0", c_ack, mem_en, c_wait_cnt);
    end
  endtask

  task automatic test_saturate();
    int unsigned model;
    s_c_req = 0; rst2 = 1;
    tick();
    rst2 = 0; s_c_req = 1; model = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_c_req && !s_c_ack && model < 15) model++;
      tick();
      n_chk++;
      if (s_cnt !== model[3:0]) begin
        n_fail++; $display("FAIL sat_cnt cycle %0d: got %0d want %0d", i, s_cnt, model);
      end
    end
    n_chk++;
    if (s_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_final: got %0d want 15", s_cnt);
    end
    s_c_req = 0;
  endtask

  task automatic new_c();
    c_we    = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 1));
    c_addr  = {27'b0, 3'($urandom_range(7, 0)), 2'b00};
    c_wdata = $urandom;
    c_req   = 1;
  endtask

  task automatic new_l();
    l_we    = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 1));
    l_addr  = {27'b0, 3'($urandom_range(7, 0)), 2'b00};
    l_wdata = $urandom;
    l_req   = 1;
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [8];
    logic [3:0]  iss_we;
    logic [31:0] iss_addr, iss_wdata;
    int          c_age, l_age, exp_next, n;
    int unsigned cnt_model;
    bit          allow;
    do_reset();
    l_lock = 0;
    for (int w = 0; w < 8; w++) begin
      c_we = 4'hF; c_addr = 32'(4*w); c_wdata = $urandom; ref_mem[w] = c_wdata; c_req = 1;
      n = 0;
      do begin tick(); n++; end while (!c_ack && n < 8);
      n_chk++;
      if (c_ack !== 1'b1) begin
        n_fail++; $display("FAIL rand_init_ack word %0d: got %b want 1", w, c_ack);
      end
      c_req = 0;
    end
    tick();
    do_reset();
    c_age = 0; l_age = 0; exp_next = -1; cnt_model = 0;
    iss_we = '0; iss_addr = '0; iss_wdata = '0;
    for (int cyc = 0; cyc < 340; cyc++) begin
      allow = (cyc < 300);
      tick();
      n_chk++;
      if (c_wait_cnt !== cnt_model[15:0]) begin
        n_fail++; $display("FAIL rand_wait_cnt cycle %0d: got %0d want %0d", cyc, c_wait_cnt, cnt_model);
      end
      n_chk++;
      if ((c_ack & l_ack) !== 1'b0) begin
        n_fail++; $display("FAIL rand_double_ack cycle %0d: got c %b l %b want not both", cyc, c_ack, l_ack);
      end
      if (c_ack === 1'b1) begin
        n_chk++;
        if (!c_req || iss_addr !== c_addr || iss_we !== c_we || iss_wdata !== c_wdata) begin
          n_fail++; $display("FAIL rand_c_access cycle %0d: got req %b addr %h we %h wd %h want 1 %h %h %h", cyc, c_req, iss_addr, iss_we, iss_wdata, c_addr, c_we, c_wdata);
        end
        if (c_we == 4'h0) begin
          n_chk++;
          if (rdata !== ref_mem[c_addr[4:2]]) begin
            n_fail++; $display("FAIL rand_c_rdata cycle %0d: got %h want %h", cyc, rdata, ref_mem[c_addr[4:2]]);
          end
        end else begin
          for (int b = 0; b < 4; b++)
            if (c_we[b]) ref_mem[c_addr[4:2]][8*b +: 8] = c_wdata[8*b +: 8];
        end
        if (exp_next != -1) begin
          n_chk++;
          if (exp_next != 0) begin
            n_fail++; $display("FAIL rand_order cycle %0d: got port C want port L", cyc);
          end
        end
        c_req = 0; c_age = 0;
        if (allow && $urandom_range(1, 0) == 1) new_c();
        exp_next = l_req ? 1 : -1;
      end else if (l_ack === 1'b1) begin
        n_chk++;
        if (!l_req || iss_addr !== l_addr || iss_we !== l_we || iss_wdata !== l_wdata) begin
          n_fail++; $display("FAIL rand_l_access cycle %0d: got req %b addr %h we %h wd %h want 1 %h %h %h", cyc, l_req, iss_addr, iss_we, iss_wdata, l_addr, l_we, l_wdata);
        end
        if (l_we == 4'h0) begin
          n_chk++;
          if (rdata !== ref_mem[l_addr[4:2]]) begin
            n_fail++; $display("FAIL rand_l_rdata cycle %0d: got %h want %h", cyc, rdata, ref_mem[l_addr[4:2]]);
          end
        end else begin
          for (int b = 0; b < 4; b++)
            if (l_we[b]) ref_mem[l_addr[4:2]][8*b +: 8] = l_wdata[8*b +: 8];
        end
        if (exp_next != -1) begin
          n_chk++;
          if (exp_next != 1) begin
            n_fail++; $display("FAIL rand_order cycle %0d: got port L want port C", cyc);
          end
        end
        l_req = 0; l_age = 0;
        if (allow && $urandom_range(1, 0) == 1) new_l();
        exp_next = c_req ? 0 : -1;
      end
      if (mem_en === 1'b1) begin
        iss_we = mem_w_en; iss_addr = mem_addr; iss_wdata = mem_wdata;
      end
      if (!c_req && allow && $urandom_range(2, 0) == 0) new_c();
      if (!l_req && allow && $urandom_range(2, 0) == 0) new_l();
      if (c_req) begin
        c_age++;
        if (c_age == 9) begin
          n_chk++; n_fail++; $display("FAIL rand_c_timeout cycle %0d: got no ack want ack within 8", cyc);
        end
      end
      if (l_req) begin
        l_age++;
        if (l_age == 9) begin
          n_chk++; n_fail++; $display("FAIL rand_l_timeout cycle %0d: got no ack want ack within 8", cyc);
        end
      end
      if (c_req && !c_ack && cnt_model < 65535) cnt_model++;
    end
    n_chk++;
    if (c_req || l_req) begin
      n_fail++; $display("FAIL rand_drain: got pending c %b l %b want 0 0", c_req, l_req);
    end
    c_req = 0; l_req = 0;
  endtask

  initial begin
    rst = 1; rst2 = 1; s_c_req = 0;
    c_req = 0; c_we = '0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = '0; l_addr = '0; l_wdata = '0; l_lock = 0;
    test_reset();
    test_core_read();
    test_sb();
    test_tie();
    test_burst();
    test_rst_issue();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Sequential arbiter that shares the single-ported, synchronous-read data memory between two requesters: the core load/store unit (port C) and the program/data loader (port L). It turns each request into one registered memory access, returns read data with a one-cycle ack pulse, stalls the core while it waits, and supports loader burst locking. It sits between the datapath's byte-enable store path (`dm_w_en`) and the data memory macro.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width. Byte-enable width is `DATA_W/8`.
- `CNT_W`, default 16: width of the core wait-cycle counter.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `c_req` in 1: core request, held until `c_ack`.
- `c_we` in DATA_W/8: core byte write enables. All zero means a read.
- `c_addr` in ADDR_W: core address.
- `c_wdata` in DATA_W: core write data.
- `c_ack` out 1: one-cycle completion pulse to the core.
- `c_stall` out 1: `c_req & ~c_ack`, combinational.
- `l_req`, `l_we`, `l_addr`, `l_wdata`, `l_ack`: loader equivalents of the core ports.
- `l_lock` in 1: while high, the loader keeps the grant for back-to-back accesses.
- `rdata` out DATA_W: read data, valid only while an ack is high.
- `mem_en` out 1: memory access strobe.
- `mem_w_en` out DATA_W/8: memory byte write enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after `mem_en`.
- `c_wait_cnt` out CNT_W: saturating count of `c_stall` cycles.

## Operation
- FSM states:
  - IDLE: memory port idle.
  - ISSUE: memory port driven from the latched request.
  - RESP: ack and read data returned.
- IDLE → ISSUE when any `req` is high. The arbiter picks a winner and latches its `we`, `addr`, `wdata` and grant index.
- ISSUE → RESP, unconditionally.
- RESP → ISSUE if another eligible request is pending; otherwise RESP → IDLE.
- Arbitration is two-way round-robin. On a tie the port not granted last wins. `last_grant` resets to L, so C wins the first tie.
- In RESP, the port being acked is ineligible, because its `req` is still high. The exception is L with `l_lock=1`: L alone stays eligible, and C is blocked.
- When `l_lock` drops, normal round-robin resumes at the next decision.
- Lock has no effect unless L holds the current grant.
- While in ISSUE:
  - `mem_en=1`; `mem_w_en`, `mem_addr`, `mem_wdata` come from the latched registers.
  - In all other states, `mem_en=0` and `mem_w_en=0`. `mem_addr` and `mem_wdata` hold their last values.
- While in RESP:
  - The ack of the granted port is 1.
  - `rdata = mem_rdata` for reads.
  - For writes `rdata` is don't-care; the bench must not check it.
- `c_wait_cnt` increments every cycle `c_stall=1`. It saturates at all-ones and never wraps.
- Requester rule: `addr`, `we` and `wdata` must be stable while `req` is high. Only the values sampled at grant are used.
- A `req` dropped before its ack is illegal. Behaviour is undefined, but the FSM must still complete the transaction and return to IDLE.

## Timing
- Reset values: state IDLE, `c_ack=0`, `l_ack=0`, `mem_en=0`, `mem_w_en=0`, `mem_addr=0`, `mem_wdata=0`, `rdata=0`, `c_wait_cnt=0`, `last_grant=L`.
- Uncontended latency: `req` seen in IDLE at cycle 0, `mem_en` at cycle 1, ack at cycle 2.
- Throughput:
  - 1 access per 2 cycles while requests keep coming (RESP→ISSUE).
  - 1 per 3 cycles when going through IDLE.
- Simultaneous `c_req` and `l_req` in IDLE: one granted per the round-robin rule. The other is served at the next RESP→ISSUE, no IDLE cycle in between.
- Reset asserted during ISSUE: the memory access on that cycle still occurs, because reset is synchronous. The transaction is dropped with no ack, and the FSM is IDLE after the edge.
- Reset asserted during RESP: the ack is still seen that cycle, and all state is cleared at the edge.
- All outputs except `c_stall` are registered.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, RESP);
  - port index constants `PORT_C=0`, `PORT_L=1`.
- Sub-module `rr_arbiter2`: combinational two-way round-robin pick from (`req_c`, `req_l`, `last_grant`, `lock`).
- Top level holds the FSM, the request latches, the ack/rdata registers and the wait counter.

## Test plan
- Core read only: `c_req`, `addr=0x10`, memory returns `0xDEADBEEF` → `mem_en` at cycle 1 with `mem_w_en=0`; `c_ack=1`, `rdata=0xDEADBEEF` at cycle 2; `c_wait_cnt=2`.
- Both request after reset → C granted first. L enters ISSUE the cycle after `c_ack`, with no IDLE cycle. The next tie goes to L.
- Loader burst with `l_lock=1`, 4 writes (`we=4'b1111`), `c_req` held throughout → four consecutive L accesses, then C is served. `c_wait_cnt` equals C's waiting cycles, 10.
- Core SB at `0x3` with `we=4'b0001` → `mem_w_en=4'b0001` for exactly one cycle, then 0.
- `rst` asserted during ISSUE → no ack follows, state IDLE, all outputs at reset values the next cycle.
- `c_req` held with `CNT_W=4` → `c_wait_cnt` stops at 15 and does not wrap.
